// File: rtl/shift_unit_pipe.sv
// ---------------------------------------------------------------------------
// shift_unit_pipe
//
// Pipelined barrel shifter for the ALU datapath. It takes a DATA_W-bit
// operand and shifts it by SHAMT places. The modes are logical left,
// logical right, arithmetic right, rotate left and rotate right. Each
// result carries a carry-out, a zero flag and an error flag for reserved
// modes.
//
// The SHAMT_W log stages (stage k shifts by 2^k) are spread over
// PIPE_STAGES register groups. When the split is uneven, the first groups
// take the extra stage. The last group is the output register.
// Valid/ready handshakes on both sides give full backpressure. The ready
// chain is combinational, so a full pipe can drain and accept on the same
// edge.
//
// Ports
//   CLK_SHIFT   in   1        clock, rising edge
//   RST_SHIFT   in   1        asynchronous reset, active low
//   IN_VALID    in   1        operand/amount/mode valid
//   IN_READY    out  1        unit accepts the input this cycle
//   A_IN_SHIFT  in   DATA_W   operand
//   SHAMT       in   SHAMT_W  shift amount
//   MODE        in   3        000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR
//   OUT_VALID   out  1        result valid
//   OUT_READY   in   1        downstream accepts the result
//   SHIFT_OUT   out  DATA_W   result
//   CARRY_OUT   out  1        last bit shifted out / last bit wrapped
//   ZERO_FLAG   out  1        SHIFT_OUT == 0
//   ERR_FLAG    out  1        result came from a reserved MODE
// ---------------------------------------------------------------------------
module shift_unit_pipe #(
    parameter int DATA_W      = 16,
    parameter int SHAMT_W     = $clog2(DATA_W),
    parameter int PIPE_STAGES = 2
) (
    input  logic               CLK_SHIFT,
    input  logic               RST_SHIFT,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [DATA_W-1:0]  A_IN_SHIFT,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [2:0]         MODE,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [DATA_W-1:0]  SHIFT_OUT,
    output logic               CARRY_OUT,
    output logic               ZERO_FLAG,
    output logic               ERR_FLAG
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    localparam int BASE_CNT  = SHAMT_W / PIPE_STAGES;
    localparam int EXTRA_CNT = SHAMT_W % PIPE_STAGES;

    // Number of log stages handled by register group g.
    function automatic int grpCount(input int g);
        return BASE_CNT + ((g < EXTRA_CNT) ? 1 : 0);
    endfunction

    // Index of the first log stage handled by register group g.
    function automatic int grpStart(input int g);
        return g * BASE_CNT + ((g < EXTRA_CNT) ? g : EXTRA_CNT);
    endfunction

    // One log stage: shift by 2^k and report the bit that leaves the word.
    // Each active stage overwrites the carry with its own outgoing bit, so
    // the carry after the last active stage is the bit at the boundary of
    // the whole shift. For rotates that is the last bit to wrap. Reserved
    // modes pass through untouched; the output group zeroes them.
    function automatic logic [DATA_W:0] shiftStep(
        input logic [DATA_W-1:0] d,
        input logic              c,
        input logic [2:0]        mode,
        input int                k
    );
        logic [DATA_W-1:0] n;
        logic              nc;
        int                amt;
        amt = 1 << k;
        n   = d;
        nc  = c;
        case (mode)
            MODE_LSL: begin
                n  = d << amt;
                nc = d[SHAMT_W'(DATA_W - amt)];
            end
            MODE_LSR: begin
                n  = d >> amt;
                nc = d[SHAMT_W'(amt - 1)];
            end
            MODE_ASR: begin
                n  = $signed(d) >>> amt;
                nc = d[SHAMT_W'(amt - 1)];
            end
            MODE_ROL: begin
                n  = (d << amt) | (d >> (DATA_W - amt));
                nc = n[0];
            end
            MODE_ROR: begin
                n  = (d >> amt) | (d << (DATA_W - amt));
                nc = n[DATA_W-1];
            end
            default: begin
                n  = d;
                nc = c;
            end
        endcase
        return {nc, n};
    endfunction

    // Inputs seen by each register group: group 0 reads the ports, and
    // every later group reads the register of the group before it.
    logic               w_grpValid [PIPE_STAGES];
    logic [DATA_W-1:0]  w_grpData  [PIPE_STAGES];
    logic [SHAMT_W-1:0] w_grpShamt [PIPE_STAGES];
    logic [2:0]         w_grpMode  [PIPE_STAGES];
    logic               w_grpCarry [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] w_regValid;
    logic [PIPE_STAGES-1:0] w_load;
    logic                   r_active;

    // The unit refuses input until the first edge after reset release.
    // This keeps a transfer from being half-taken while the flops are
    // still held in reset.
    always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
        if (!RST_SHIFT) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_grpValid[0] = IN_VALID & r_active;
    assign w_grpData[0]  = A_IN_SHIFT;
    assign w_grpShamt[0] = SHAMT;
    assign w_grpMode[0]  = MODE;
    assign w_grpCarry[0] = 1'b0;

    // Load-enable chain, computed from the output back to the input. A
    // group loads when it is empty or when the group after it loads. The
    // output group loads when downstream takes the result or holds none.
    always_comb begin
        w_load = '0;
        w_load[PIPE_STAGES-1] = OUT_READY | ~w_regValid[PIPE_STAGES-1];
        for (int i = PIPE_STAGES - 2; i >= 0; i--) begin
            w_load[i] = ~w_regValid[i] | w_load[i+1];
        end
    end

    assign IN_READY = r_active & w_load[0];

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_grp
        localparam int START = grpStart(g);
        localparam int COUNT = grpCount(g);

        logic [DATA_W-1:0] w_shData;
        logic              w_shCarry;
        logic [DATA_W:0]   w_step;

        // Apply this group's slice of log stages. Each stage runs only
        // when its SHAMT bit is set.
        always_comb begin
            w_shData  = w_grpData[g];
            w_shCarry = w_grpCarry[g];
            w_step    = '0;
            for (int k = START; k < START + COUNT; k++) begin
                if ((w_grpShamt[g] & (SHAMT_W'(1) << k)) != '0) begin
                    w_step    = shiftStep(w_shData, w_shCarry, w_grpMode[g], k);
                    w_shData  = w_step[DATA_W-1:0];
                    w_shCarry = w_step[DATA_W];
                end
            end
        end

        if (g < PIPE_STAGES - 1) begin : g_mid
            logic               r_valid;
            logic [DATA_W-1:0]  r_data;
            logic [SHAMT_W-1:0] r_shamt;
            logic [2:0]         r_mode;
            logic               r_carry;

            // Intermediate register group. The payload is captured only
            // when a real transaction arrives, so bubbles leave it alone.
            always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
                if (!RST_SHIFT) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_shamt <= '0;
                    r_mode  <= '0;
                    r_carry <= 1'b0;
                end else if (w_load[g]) begin
                    r_valid <= w_grpValid[g];
                    if (w_grpValid[g]) begin
                        r_data  <= w_shData;
                        r_shamt <= w_grpShamt[g];
                        r_mode  <= w_grpMode[g];
                        r_carry <= w_shCarry;
                    end
                end
            end

            assign w_regValid[g]   = r_valid;
            assign w_grpValid[g+1] = r_valid;
            assign w_grpData[g+1]  = r_data;
            assign w_grpShamt[g+1] = r_shamt;
            assign w_grpMode[g+1]  = r_mode;
            assign w_grpCarry[g+1] = r_carry;
        end else begin : g_out
            logic              r_valid;
            logic [DATA_W-1:0] r_data;
            logic              r_carry;
            logic              r_zero;
            logic              r_err;
            logic              w_reserved;

            assign w_reserved = (w_grpMode[g] > MODE_ROR);

            // Output register group. The flags are formed here and
            // registered together with the result. With no new
            // transaction the result and flags hold their last values.
            always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
                if (!RST_SHIFT) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_carry <= 1'b0;
                    r_zero  <= 1'b0;
                    r_err   <= 1'b0;
                end else if (w_load[g]) begin
                    r_valid <= w_grpValid[g];
                    if (w_grpValid[g]) begin
                        if (w_reserved) begin
                            r_data  <= '0;
                            r_carry <= 1'b0;
                            r_zero  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_data  <= w_shData;
                            r_carry <= w_shCarry;
                            r_zero  <= (w_shData == '0);
                            r_err   <= 1'b0;
                        end
                    end
                end
            end

            assign w_regValid[g] = r_valid;
            assign OUT_VALID     = r_valid;
            assign SHIFT_OUT     = r_data;
            assign CARRY_OUT     = r_carry;
            assign ZERO_FLAG     = r_zero;
            assign ERR_FLAG      = r_err;
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_pipe
//
// Scoreboard bench for shift_unit_pipe (DATA_W=16, PIPE_STAGES=2). The
// driver pushes the expected result when a transfer is accepted. A separate
// monitor pops and compares whenever the unit hands a result downstream.
// The monitor also checks that outputs hold steady during a stall.
// ---------------------------------------------------------------------------
module tb_shift_unit_pipe;

    localparam int DATA_W      = 16;
    localparam int SHAMT_W     = 4;
    localparam int PIPE_STAGES = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              zero;
        logic              err;
    } expect_t;

    logic               clkShift;
    logic               rstShift;
    logic               inValid;
    logic               inReady;
    logic [DATA_W-1:0]  aIn;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0]         mode;
    logic               outValid;
    logic               outReady;
    logic [DATA_W-1:0]  shiftOut;
    logic               carryOut;
    logic               zeroFlag;
    logic               errFlag;

    expect_t            expQ[$];
    expect_t            monExp;
    expect_t            holdVal;
    logic               prevHold;
    int                 checks;
    int                 errors;
    logic               drvDone;
    logic [DATA_W-1:0]  rndA;
    logic [SHAMT_W-1:0] rndS;
    logic [2:0]         rndM;

    shift_unit_pipe #(
        .DATA_W      (DATA_W),
        .SHAMT_W     (SHAMT_W),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .CLK_SHIFT  (clkShift),
        .RST_SHIFT  (rstShift),
        .IN_VALID   (inValid),
        .IN_READY   (inReady),
        .A_IN_SHIFT (aIn),
        .SHAMT      (shamt),
        .MODE       (mode),
        .OUT_VALID  (outValid),
        .OUT_READY  (outReady),
        .SHIFT_OUT  (shiftOut),
        .CARRY_OUT  (carryOut),
        .ZERO_FLAG  (zeroFlag),
        .ERR_FLAG   (errFlag)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    initial begin
        clkShift = 1'b0;
        forever #5 clkShift = ~clkShift;
    end

    // Hard stop in case something deadlocks beyond the per-wait budgets.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic expect_t mk(input logic [DATA_W-1:0] d, input logic c, input logic z, input logic e);
        expect_t r;
        r.data  = d;
        r.carry = c;
        r.zero  = z;
        r.err   = e;
        return r;
    endfunction

    // Reference model: computes the whole shift in one step with plain
    // integer arithmetic.
    function automatic expect_t refModel(input logic [DATA_W-1:0] a, input int s, input logic [2:0] m);
        int      av;
        int      res;
        int      c;
        expect_t e;
        av  = int'(a);
        res = 0;
        c   = 0;
        case (m)
            3'd0: begin
                res = (av << s) & 'hFFFF;
                c   = (s > 0) ? ((av >> (DATA_W - s)) & 1) : 0;
            end
            3'd1: begin
                res = av >> s;
                c   = (s > 0) ? ((av >> (s - 1)) & 1) : 0;
            end
            3'd2: begin
                res = (int'($signed(a)) >>> s) & 'hFFFF;
                c   = (s > 0) ? ((av >> (s - 1)) & 1) : 0;
            end
            3'd3: begin
                res = ((av << s) | (av >> (DATA_W - s))) & 'hFFFF;
                c   = (s > 0) ? (res & 1) : 0;
            end
            3'd4: begin
                res = ((av >> s) | (av << (DATA_W - s))) & 'hFFFF;
                c   = (s > 0) ? ((res >> (DATA_W - 1)) & 1) : 0;
            end
            default: begin
                res = 0;
                c   = 0;
            end
        endcase
        e.data  = res[DATA_W-1:0];
        e.carry = c[0];
        e.zero  = (res == 0);
        e.err   = (m > 3'd4);
        return e;
    endfunction

    // Drive one transaction, starting at a falling edge. Wait (bounded)
    // for acceptance, then record the expected response.
    task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [SHAMT_W-1:0] s,
                                 input logic [2:0] m, input expect_t e);
        int waitCycles;
        waitCycles = 0;
        aIn     = a;
        shamt   = s;
        mode    = m;
        inValid = 1'b1;
        #3;
        while (!inReady) begin
            @(negedge clkShift);
            #3;
            waitCycles++;
            if (waitCycles > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got IN_READY=0 for %0d cycles, expected acceptance", waitCycles);
                @(negedge clkShift);
                inValid = 1'b0;
                return;
            end
        end
        expQ.push_back(e);
        @(negedge clkShift);
        inValid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clkShift);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", expQ.size());
        end
    endtask

    // Monitor: sample between the falling and the next rising edge. Pop
    // and compare each result the unit hands over. Also check that a
    // stalled result stays put.
    always begin
        @(negedge clkShift);
        #3;
        if (rstShift) begin
            if (prevHold) begin
                checkOutput("hold_valid", outValid, 1);
                checkOutput("hold_data", shiftOut, holdVal.data);
                checkOutput("hold_carry", carryOut, holdVal.carry);
                checkOutput("hold_zero", zeroFlag, holdVal.zero);
                checkOutput("hold_err", errFlag, holdVal.err);
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no result", shiftOut);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("out_data", shiftOut, monExp.data);
                    checkOutput("out_carry", carryOut, monExp.carry);
                    checkOutput("out_zero", zeroFlag, monExp.zero);
                    checkOutput("out_err", errFlag, monExp.err);
                end
            end
            prevHold = outValid && !outReady;
            holdVal  = {shiftOut, carryOut, zeroFlag, errFlag};
        end else begin
            prevHold = 1'b0;
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prevHold = 1'b0;
        holdVal  = '0;
        drvDone  = 1'b0;
        inValid  = 1'b0;
        aIn      = '0;
        shamt    = '0;
        mode     = '0;
        outReady = 1'b1;
        rstShift = 1'b0;

        // Reset state
        #1;
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_shift_out", shiftOut, 0);
        checkOutput("reset_carry", carryOut, 0);
        checkOutput("reset_zero", zeroFlag, 0);
        checkOutput("reset_err", errFlag, 0);
        repeat (3) @(negedge clkShift);
        #1 rstShift = 1'b1;
        @(posedge clkShift);
        #1 checkOutput("ready_after_reset", inReady, 1);
        @(negedge clkShift);

        // Directed operations with hand-computed results
        $display("[TB] directed operations");
        applyStimulus(16'h8001, 4'd1,  3'd0, mk(16'h0002, 1'b1, 1'b0, 1'b0));
        applyStimulus(16'h8000, 4'd15, 3'd2, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
        applyStimulus(16'h8000, 4'd15, 3'd1, mk(16'h0001, 1'b0, 1'b0, 1'b0));
        applyStimulus(16'h0003, 4'd1,  3'd4, mk(16'h8001, 1'b1, 1'b0, 1'b0));
        applyStimulus(16'h8001, 4'd4,  3'd3, mk(16'h0018, 1'b0, 1'b0, 1'b0));
        applyStimulus(16'h8000, 4'd1,  3'd0, mk(16'h0000, 1'b1, 1'b1, 1'b0));
        applyStimulus(16'h0003, 4'd15, 3'd0, mk(16'h8000, 1'b1, 1'b0, 1'b0));
        for (int m = 0; m < 5; m++) begin
            applyStimulus(16'h1234, 4'd0, 3'(m), mk(16'h1234, 1'b0, 1'b0, 1'b0));
        end
        waitDrain();

        // Backpressure: six back-to-back inputs against a five-cycle stall
        $display("[TB] backpressure");
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    applyStimulus(16'(i), 4'd1, 3'd0, mk(16'(2 * i), 1'b0, 1'b0, 1'b0));
                end
            end
            begin
                outReady = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    if (c >= 2) begin
                        #3 checkOutput("stall_in_ready", inReady, 0);
                    end
                    @(negedge clkShift);
                end
                outReady = 1'b1;
            end
        join
        waitDrain();

        // Reserved mode, then a legal op clears the error flag
        $display("[TB] reserved mode");
        applyStimulus(16'hFFFF, 4'd5, 3'b110, mk(16'h0000, 1'b0, 1'b1, 1'b1));
        applyStimulus(16'h0001, 4'd3, 3'd0,   mk(16'h0008, 1'b0, 1'b0, 1'b0));
        waitDrain();

        // Randomized traffic with random backpressure
        $display("[TB] random traffic");
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    rndA = 16'($urandom);
                    rndS = 4'($urandom_range(0, 15));
                    rndM = 3'($urandom_range(0, 7));
                    applyStimulus(rndA, rndS, rndM, refModel(rndA, int'(rndS), rndM));
                    if ($urandom_range(0, 3) == 0) @(negedge clkShift);
                end
                drvDone = 1'b1;
            end
            begin
                while (!drvDone) begin
                    @(negedge clkShift);
                    outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join
        outReady = 1'b1;
        waitDrain();

        // Reset with two transactions in flight
        $display("[TB] reset mid-operation");
        outReady = 1'b0;
        applyStimulus(16'h00F0, 4'd1, 3'd0, mk(16'h01E0, 1'b0, 1'b0, 1'b0));
        applyStimulus(16'h0F00, 4'd2, 3'd0, mk(16'h3C00, 1'b0, 1'b0, 1'b0));
        #1 checkOutput("pre_reset_valid", outValid, 1);
        #1 rstShift = 1'b0;
        #1;
        checkOutput("midreset_out_valid", outValid, 0);
        checkOutput("midreset_shift_out", shiftOut, 0);
        checkOutput("midreset_carry", carryOut, 0);
        checkOutput("midreset_zero", zeroFlag, 0);
        checkOutput("midreset_err", errFlag, 0);
        expQ.delete();
        repeat (2) @(negedge clkShift);
        outReady = 1'b1;
        #1 rstShift = 1'b1;
        @(posedge clkShift);
        #1 checkOutput("ready_after_midreset", inReady, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clkShift);
            #1 checkOutput("no_stale_output", outValid, 0);
        end

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
